// File: rtl/jtag_pkg.sv
// Shared JTAG instruction-register constants: default IR width, standard opcodes,
// instruction indices and the default opcode table builder.
package jtag_pkg;

    localparam int DEF_IR_WIDTH = 4;
    localparam int DEF_NUM_INST = 6;

    localparam logic [DEF_IR_WIDTH-1:0] E_BYPASS         = 4'b1111;
    localparam logic [DEF_IR_WIDTH-1:0] E_SAMPLE_PRELOAD = 4'b0010;
    localparam logic [DEF_IR_WIDTH-1:0] E_EXTEST         = 4'b0000;
    localparam logic [DEF_IR_WIDTH-1:0] E_IDCODE         = 4'b0001;
    localparam logic [DEF_IR_WIDTH-1:0] E_CLAMP          = 4'b0100;
    localparam logic [DEF_IR_WIDTH-1:0] E_IC_RESET       = 4'b0101;

    localparam int IDX_BYPASS         = 0;
    localparam int IDX_SAMPLE_PRELOAD = 1;
    localparam int IDX_EXTEST         = 2;
    localparam int IDX_IDCODE         = 3;
    localparam int IDX_CLAMP          = 4;
    localparam int IDX_IC_RESET       = 5;

    // Entry i occupies bits [i*DEF_IR_WIDTH +: DEF_IR_WIDTH].
    function automatic logic [DEF_NUM_INST*DEF_IR_WIDTH-1:0] default_opcodes();
        logic [DEF_NUM_INST*DEF_IR_WIDTH-1:0] tab;
        tab = '1;
        tab[IDX_BYPASS*DEF_IR_WIDTH         +: DEF_IR_WIDTH] = E_BYPASS;
        tab[IDX_SAMPLE_PRELOAD*DEF_IR_WIDTH +: DEF_IR_WIDTH] = E_SAMPLE_PRELOAD;
        tab[IDX_EXTEST*DEF_IR_WIDTH         +: DEF_IR_WIDTH] = E_EXTEST;
        tab[IDX_IDCODE*DEF_IR_WIDTH         +: DEF_IR_WIDTH] = E_IDCODE;
        tab[IDX_CLAMP*DEF_IR_WIDTH          +: DEF_IR_WIDTH] = E_CLAMP;
        tab[IDX_IC_RESET*DEF_IR_WIDTH       +: DEF_IR_WIDTH] = E_IC_RESET;
        return tab;
    endfunction

endpackage

// File: rtl/ir_decoder.sv
// Table-driven IR opcode decoder: shift-register contents to instruction index.
// Latency: purely combinational.
// Backpressure: none; the result is consumed only when the IR is updated.
module ir_decoder
    import jtag_pkg::*;
#(
    parameter int                            IR_WIDTH     = DEF_IR_WIDTH,
    parameter int                            NUM_INST     = DEF_NUM_INST,
    parameter logic [NUM_INST*IR_WIDTH-1:0]  OPCODES      = default_opcodes(),
    parameter int                            BYPASS_IDX   = IDX_BYPASS,
    parameter logic [NUM_INST-1:0]           PRIVATE_MASK = NUM_INST'(1) << IDX_IC_RESET,
    parameter int                            IDX_W        = $clog2(NUM_INST)
) (
    input  logic [IR_WIDTH-1:0] sr,
    input  logic                private_en,
    output logic [IDX_W-1:0]    decoded
);

    localparam logic [IDX_W-1:0] BYP = IDX_W'(BYPASS_IDX);

    logic found;

    // Only the lowest matching entry counts; a gated private match falls to BYPASS
    // rather than continuing the search.
    always_comb begin
        decoded = BYP;
        found   = 1'b0;
        for (int i = 0; i < NUM_INST; i++) begin
            if (!found && (OPCODES[i*IR_WIDTH +: IR_WIDTH] == sr)) begin
                found = 1'b1;
                if (!PRIVATE_MASK[i] || private_en) begin
                    decoded = IDX_W'(i);
                end
            end
        end
        if (&sr) begin
            decoded = BYP;
        end
    end

endmodule

// File: rtl/jtag_ir_param.sv
// Parametrised JTAG instruction register: capture/shift/update chain with one-hot latch.
// Latency: tdo one edge after capture/shift; instructions/opcode_out/update_valid one edge after update_ir.
// Backpressure: none; TAP enables are obeyed every tck edge, bad-length updates are dropped.
module jtag_ir_param
    import jtag_pkg::*;
#(
    parameter int                            IR_WIDTH     = DEF_IR_WIDTH,
    parameter int                            NUM_INST     = DEF_NUM_INST,
    parameter logic [NUM_INST*IR_WIDTH-1:0]  OPCODES      = default_opcodes(),
    parameter int                            BYPASS_IDX   = IDX_BYPASS,
    parameter int                            RESET_IDX    = IDX_IDCODE,
    parameter logic [NUM_INST-1:0]           PRIVATE_MASK = NUM_INST'(1) << IDX_IC_RESET,
    parameter bit                            STRICT_LEN   = 1'b1
) (
    input  logic                tck,
    input  logic                tl_reset,
    input  logic                tdi,
    input  logic                capture_ir,
    input  logic                shift_ir,
    input  logic                update_ir,
    input  logic                private_en,
    input  logic [IR_WIDTH-1:0] capture_status,
    output logic                tdo,
    output logic [NUM_INST-1:0] instructions,
    output logic [IR_WIDTH-1:0] opcode_out,
    output logic                update_valid,
    output logic                len_error
);

    localparam int IDX_W = $clog2(NUM_INST);
    localparam int CNT_W = $clog2(IR_WIDTH + 2);

    localparam logic [CNT_W-1:0]    CNT_FULL     = CNT_W'(IR_WIDTH);
    localparam logic [CNT_W-1:0]    CNT_MAX      = CNT_W'(IR_WIDTH + 1);
    localparam logic [IR_WIDTH-1:0] SR_RESET     = {{(IR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IR_WIDTH-1:0] RESET_OP     = OPCODES[RESET_IDX*IR_WIDTH +: IR_WIDTH];
    localparam logic [NUM_INST-1:0] RESET_ONEHOT = NUM_INST'(1) << RESET_IDX;

    if (IR_WIDTH < 2 || NUM_INST < 2) begin : g_bad_size
        $error("jtag_ir_param: IR_WIDTH and NUM_INST must both be >= 2");
    end
    if (BYPASS_IDX < 0 || BYPASS_IDX >= NUM_INST || RESET_IDX < 0 || RESET_IDX >= NUM_INST) begin : g_bad_idx
        $error("jtag_ir_param: BYPASS_IDX and RESET_IDX must be < NUM_INST");
    end else if (OPCODES[BYPASS_IDX*IR_WIDTH +: IR_WIDTH] != {IR_WIDTH{1'b1}}) begin : g_bad_bypass
        $error("jtag_ir_param: BYPASS opcode must be all ones");
    end

    logic [IR_WIDTH-1:0] sr;
    logic [CNT_W-1:0]    cnt;
    logic [IR_WIDTH-1:0] cap_val;
    logic [IDX_W-1:0]    decoded;
    logic [NUM_INST-1:0] dec_onehot;
    logic [IR_WIDTH-1:0] dec_opcode;
    logic                len_ok;

    ir_decoder #(
        .IR_WIDTH     (IR_WIDTH),
        .NUM_INST     (NUM_INST),
        .OPCODES      (OPCODES),
        .BYPASS_IDX   (BYPASS_IDX),
        .PRIVATE_MASK (PRIVATE_MASK),
        .IDX_W        (IDX_W)
    ) u_dec (
        .sr         (sr),
        .private_en (private_en),
        .decoded    (decoded)
    );

    // The two LSBs of the captured value are fixed at 01 so a broken chain is visible.
    always_comb begin
        cap_val      = capture_status;
        cap_val[1:0] = 2'b01;
    end

    always_comb begin
        dec_onehot = '0;
        dec_opcode = '1;
        for (int i = 0; i < NUM_INST; i++) begin
            if (decoded == IDX_W'(i)) begin
                dec_onehot[i] = 1'b1;
                dec_opcode    = OPCODES[i*IR_WIDTH +: IR_WIDTH];
            end
        end
    end

    assign len_ok = !STRICT_LEN || (cnt == CNT_FULL);
    assign tdo    = sr[0];

    always_ff @(posedge tck) begin
        if (tl_reset) begin
            sr           <= SR_RESET;
            cnt          <= '0;
            instructions <= RESET_ONEHOT;
            opcode_out   <= RESET_OP;
            update_valid <= 1'b0;
            len_error    <= 1'b0;
        end else begin
            update_valid <= 1'b0;
            if (capture_ir) begin
                sr        <= cap_val;
                cnt       <= '0;
                len_error <= 1'b0;
            end else if (shift_ir) begin
                sr <= {tdi, sr[IR_WIDTH-1:1]};
                // Saturate so an over-long shift can never wrap back to a legal length.
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (update_ir) begin
                if (len_ok) begin
                    instructions <= dec_onehot;
                    opcode_out   <= dec_opcode;
                    update_valid <= 1'b1;
                    len_error    <= 1'b0;
                end else begin
                    len_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_ir_param.sv
// Directed vector bench for jtag_ir_param with the default opcode table.
module tb_jtag_ir_param;

    logic       tck = 1'b0;
    logic       tl_reset;
    logic       tdi;
    logic       capture_ir;
    logic       shift_ir;
    logic       update_ir;
    logic       private_en;
    logic [3:0] capture_status;
    logic       tdo;
    logic [5:0] instructions;
    logic [3:0] opcode_out;
    logic       update_valid;
    logic       len_error;

    int checks = 0;
    int errors = 0;

    always #5 tck = ~tck;

    jtag_ir_param dut (
        .tck            (tck),
        .tl_reset       (tl_reset),
        .tdi            (tdi),
        .capture_ir     (capture_ir),
        .shift_ir       (shift_ir),
        .update_ir      (update_ir),
        .private_en     (private_en),
        .capture_status (capture_status),
        .tdo            (tdo),
        .instructions   (instructions),
        .opcode_out     (opcode_out),
        .update_valid   (update_valid),
        .len_error      (len_error)
    );

    typedef struct {
        logic       rst, cap, sh, upd, tdi, pen;
        logic [3:0] st;
        logic       e_tdo;
        logic [5:0] e_inst;
        logic [3:0] e_op;
        logic       e_uv, e_le;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, c, s, u, t, p, input logic [3:0] st,
                       input logic etdo, input logic [5:0] ei, input logic [3:0] eo,
                       input logic euv, input logic ele);
        vec_t v;
        v.rst = r; v.cap = c; v.sh = s; v.upd = u; v.tdi = t; v.pen = p; v.st = st;
        v.e_tdo = etdo; v.e_inst = ei; v.e_op = eo; v.e_uv = euv; v.e_le = ele;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled just after the rising edge.
    task automatic drive(input logic r, c, s, u, t, p, input logic [3:0] st);
        @(negedge tck);
        tl_reset = r; capture_ir = c; shift_ir = s; update_ir = u;
        tdi = t; private_en = p; capture_status = st;
        @(posedge tck);
        #1;
    endtask

    task automatic check_all(input string tag, input logic etdo, input logic [5:0] ei,
                             input logic [3:0] eo, input logic euv, input logic ele);
        chk({tag, " tdo"}, {7'd0, tdo}, {7'd0, etdo});
        chk({tag, " instructions"}, {2'd0, instructions}, {2'd0, ei});
        chk({tag, " opcode_out"}, {4'd0, opcode_out}, {4'd0, eo});
        chk({tag, " update_valid"}, {7'd0, update_valid}, {7'd0, euv});
        chk({tag, " len_error"}, {7'd0, len_error}, {7'd0, ele});
    endtask

    initial begin
        tl_reset = 1'b1; capture_ir = 1'b0; shift_ir = 1'b0; update_ir = 1'b0;
        tdi = 1'b0; private_en = 1'b0; capture_status = 4'b0000;

        //  rst cap sh upd tdi pen status   tdo inst       op       uv le
        // reset and idle
        add(1, 0, 0, 0, 0, 0, 4'b0000,  1, 6'b001000, 4'b0001, 0, 0);
        add(0, 0, 0, 0, 0, 0, 4'b0000,  1, 6'b001000, 4'b0001, 0, 0);
        // capture 1011 -> sr 1001, shift out 1,0,0,1 while shifting in EXTEST (0000)
        add(0, 1, 0, 0, 0, 0, 4'b1011,  1, 6'b001000, 4'b0001, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  0, 6'b001000, 4'b0001, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  0, 6'b001000, 4'b0001, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  1, 6'b001000, 4'b0001, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  0, 6'b001000, 4'b0001, 0, 0);
        add(0, 0, 0, 1, 0, 0, 4'b0000,  0, 6'b000100, 4'b0000, 1, 0);
        add(0, 0, 0, 0, 0, 0, 4'b0000,  0, 6'b000100, 4'b0000, 0, 0);
        // SAMPLE/PRELOAD 0010 (bits 0,1,0,0 LSB first)
        add(0, 1, 0, 0, 0, 0, 4'b0000,  1, 6'b000100, 4'b0000, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  0, 6'b000100, 4'b0000, 0, 0);
        add(0, 0, 1, 0, 1, 0, 4'b0000,  0, 6'b000100, 4'b0000, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  0, 6'b000100, 4'b0000, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  0, 6'b000100, 4'b0000, 0, 0);
        add(0, 0, 0, 1, 0, 0, 4'b0000,  0, 6'b000010, 4'b0010, 1, 0);
        // unmatched 1010 -> BYPASS, opcode all ones
        add(0, 1, 0, 0, 0, 0, 4'b0000,  1, 6'b000010, 4'b0010, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  0, 6'b000010, 4'b0010, 0, 0);
        add(0, 0, 1, 0, 1, 0, 4'b0000,  0, 6'b000010, 4'b0010, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  0, 6'b000010, 4'b0010, 0, 0);
        add(0, 0, 1, 0, 1, 0, 4'b0000,  0, 6'b000010, 4'b0010, 0, 0);
        add(0, 0, 0, 1, 0, 0, 4'b0000,  0, 6'b000001, 4'b1111, 1, 0);
        // 3-bit shift rejected; capture clears len_error
        add(0, 1, 0, 0, 0, 0, 4'b0000,  1, 6'b000001, 4'b1111, 0, 0);
        add(0, 0, 1, 0, 1, 0, 4'b0000,  0, 6'b000001, 4'b1111, 0, 0);
        add(0, 0, 1, 0, 1, 0, 4'b0000,  0, 6'b000001, 4'b1111, 0, 0);
        add(0, 0, 1, 0, 1, 0, 4'b0000,  0, 6'b000001, 4'b1111, 0, 0);
        add(0, 0, 0, 1, 0, 0, 4'b0000,  0, 6'b000001, 4'b1111, 0, 1);
        add(0, 0, 0, 0, 0, 0, 4'b0000,  0, 6'b000001, 4'b1111, 0, 1);
        add(0, 1, 0, 0, 0, 0, 4'b0000,  1, 6'b000001, 4'b1111, 0, 0);
        // 5-bit shift ending with sr=0000 (EXTEST) rejected
        add(0, 0, 1, 0, 1, 0, 4'b0000,  0, 6'b000001, 4'b1111, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  0, 6'b000001, 4'b1111, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  0, 6'b000001, 4'b1111, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  1, 6'b000001, 4'b1111, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  0, 6'b000001, 4'b1111, 0, 0);
        add(0, 0, 0, 1, 0, 0, 4'b0000,  0, 6'b000001, 4'b1111, 0, 1);
        // private IC_RESET 0101 with private_en=0 -> BYPASS
        add(0, 1, 0, 0, 0, 0, 4'b0000,  1, 6'b000001, 4'b1111, 0, 0);
        add(0, 0, 1, 0, 1, 0, 4'b0000,  0, 6'b000001, 4'b1111, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  0, 6'b000001, 4'b1111, 0, 0);
        add(0, 0, 1, 0, 1, 0, 4'b0000,  0, 6'b000001, 4'b1111, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  1, 6'b000001, 4'b1111, 0, 0);
        add(0, 0, 0, 1, 0, 0, 4'b0000,  1, 6'b000001, 4'b1111, 1, 0);
        // same with private_en=1 -> IC_RESET; dropping private_en afterwards keeps it
        add(0, 1, 0, 0, 0, 0, 4'b0000,  1, 6'b000001, 4'b1111, 0, 0);
        add(0, 0, 1, 0, 1, 0, 4'b0000,  0, 6'b000001, 4'b1111, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  0, 6'b000001, 4'b1111, 0, 0);
        add(0, 0, 1, 0, 1, 0, 4'b0000,  0, 6'b000001, 4'b1111, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  1, 6'b000001, 4'b1111, 0, 0);
        add(0, 0, 0, 1, 0, 1, 4'b0000,  1, 6'b100000, 4'b0101, 1, 0);
        add(0, 0, 0, 0, 0, 0, 4'b0000,  1, 6'b100000, 4'b0101, 0, 0);
        // capture+update: update sees old sr 0101 (gated now), capture still happens
        add(0, 1, 0, 1, 0, 0, 4'b0000,  1, 6'b000001, 4'b1111, 1, 0);
        // capture+shift: capture wins
        add(0, 1, 1, 0, 0, 0, 4'b0000,  1, 6'b000001, 4'b1111, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  0, 6'b000001, 4'b1111, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  0, 6'b000001, 4'b1111, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  0, 6'b000001, 4'b1111, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  0, 6'b000001, 4'b1111, 0, 0);
        // shift+update: update uses pre-edge sr/cnt, then cnt=5 rejects the next update
        add(0, 0, 1, 1, 1, 0, 4'b0000,  0, 6'b000100, 4'b0000, 1, 0);
        add(0, 0, 0, 1, 0, 0, 4'b0000,  0, 6'b000100, 4'b0000, 0, 1);
        // held update_ir gives back-to-back pulses
        add(0, 1, 0, 0, 0, 0, 4'b0000,  1, 6'b000100, 4'b0000, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  0, 6'b000100, 4'b0000, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  0, 6'b000100, 4'b0000, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  0, 6'b000100, 4'b0000, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  0, 6'b000100, 4'b0000, 0, 0);
        add(0, 0, 0, 1, 0, 0, 4'b0000,  0, 6'b000100, 4'b0000, 1, 0);
        add(0, 0, 0, 1, 0, 0, 4'b0000,  0, 6'b000100, 4'b0000, 1, 0);
        add(0, 0, 0, 0, 0, 0, 4'b0000,  0, 6'b000100, 4'b0000, 0, 0);
        // reset mid-shift, then a 2-bit shift + update is rejected
        add(0, 1, 0, 0, 0, 0, 4'b0000,  1, 6'b000100, 4'b0000, 0, 0);
        add(0, 0, 1, 0, 1, 0, 4'b0000,  0, 6'b000100, 4'b0000, 0, 0);
        add(0, 0, 1, 0, 1, 0, 4'b0000,  0, 6'b000100, 4'b0000, 0, 0);
        add(1, 0, 1, 0, 1, 0, 4'b0000,  1, 6'b001000, 4'b0001, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4'b0000,  0, 6'b001000, 4'b0001, 0, 0);
        add(0, 0, 1, 0, 1, 0, 4'b0000,  0, 6'b001000, 4'b0001, 0, 0);
        add(0, 0, 0, 1, 0, 0, 4'b0000,  0, 6'b001000, 4'b0001, 0, 1);

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].rst, vecs[k].cap, vecs[k].sh, vecs[k].upd,
                  vecs[k].tdi, vecs[k].pen, vecs[k].st);
            check_all($sformatf("vec%0d", k), vecs[k].e_tdo, vecs[k].e_inst,
                      vecs[k].e_op, vecs[k].e_uv, vecs[k].e_le);
        end

        // 12-bit held shift: a wrapping counter would read 4 again; must still reject.
        drive(0, 1, 0, 0, 0, 0, 4'b0000);
        for (int n = 0; n < 12; n++) begin
            drive(0, 0, 1, 0, 0, 0, 4'b0000);
        end
        drive(0, 0, 0, 1, 0, 0, 4'b0000);
        check_all("sat12", 1'b0, 6'b001000, 4'b0001, 1'b0, 1'b1);

        // Exactly four bits after that must be accepted (CLAMP 0100: bits 0,0,1,0).
        drive(0, 1, 0, 0, 0, 0, 4'b0000);
        drive(0, 0, 1, 0, 0, 0, 4'b0000);
        drive(0, 0, 1, 0, 0, 0, 4'b0000);
        drive(0, 0, 1, 0, 1, 0, 4'b0000);
        drive(0, 0, 1, 0, 0, 0, 4'b0000);
        drive(0, 0, 0, 1, 0, 0, 4'b0000);
        check_all("clamp", 1'b0, 6'b010000, 4'b0100, 1'b1, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 4'b0000);
        check_all("clamp_idle", 1'b0, 6'b010000, 4'b0100, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
